// File: rtl/snax_tcdm_arb_pkg.sv
// Shared types and constants for the SNAX TCDM request arbiter.
package snax_tcdm_arb_pkg;

  localparam int unsigned NumInpDefault    = 4;
  localparam int unsigned DataWidthDefault = 64;
  localparam int unsigned AddrWidth        = 32;
  localparam int unsigned PerfCntWidth     = 32;

  // Width of a requester ID; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned IdWidth = id_width(NumInpDefault);
  typedef logic [IdWidth-1:0] arb_id_t;

  typedef struct packed {
    logic [AddrWidth-1:0]          addr;
    logic                          write;
    logic [DataWidthDefault-1:0]   data;
    logic [DataWidthDefault/8-1:0] strb;
  } arb_q_t;

  typedef struct packed {
    arb_q_t q;
    logic   q_valid;
  } arb_req_t;

  typedef struct packed {
    logic [DataWidthDefault-1:0] data;
  } arb_p_t;

  typedef struct packed {
    arb_p_t p;
    logic   p_valid;
    logic   q_ready;
  } arb_rsp_t;

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO holding requester IDs of in-flight reads.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW:0] FullCount = (PtrW+1)'(DEPTH);

  logic [PtrW-1:0]       wr_ptr, rd_ptr;
  logic [PtrW:0]         count;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  do_push, do_pop;

  assign full_o  = (count == FullCount);
  assign empty_o = (count == '0);
  // Full is taken from the current count, so a pop never frees room for a push in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PtrW+1)'(1);
        2'b01:   count <= count - (PtrW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/snax_tcdm_rr_arbiter.sv
// Round-robin selector with a grant lock that holds the choice while a request stalls.
module snax_tcdm_rr_arbiter #(
  parameter int unsigned NumInp = 4,
  parameter int unsigned IdW    = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumInp-1:0] req_i,
  input  logic              out_valid_i,
  input  logic              out_ready_i,
  output logic [IdW-1:0]    sel_o,
  output logic              valid_o
);

  logic [IdW-1:0] rr_ptr, lock_sel, search_sel;
  logic           locked, found;

  // First active request at or above rr_ptr, wrapping around.
  always_comb begin
    search_sel = rr_ptr;
    found      = 1'b0;
    for (int k = 0; k < NumInp; k++) begin
      if (!found && req_i[(int'(rr_ptr) + k) % NumInp]) begin
        found      = 1'b1;
        search_sel = IdW'((int'(rr_ptr) + k) % NumInp);
      end
    end
  end

  // A pending grant overrides the search so the outgoing request stays stable.
  always_comb begin
    sel_o   = locked ? lock_sel : search_sel;
    valid_o = locked ? req_i[lock_sel] : found;
  end

  // Advance past the winner on a handshake; latch the winner while it waits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr   <= '0;
      locked   <= 1'b0;
      lock_sel <= '0;
    end else if (out_valid_i && out_ready_i) begin
      rr_ptr <= (sel_o == IdW'(NumInp-1)) ? '0 : sel_o + IdW'(1);
      locked <= 1'b0;
    end else if (out_valid_i) begin
      locked   <= 1'b1;
      lock_sel <= sel_o;
    end else begin
      locked <= 1'b0;
    end
  end

endmodule

// File: rtl/snax_tcdm_req_arbiter.sv
// Shares one TCDM reqrsp port among NumInp requesters and routes read
// responses back in order using an ID FIFO.
// Optional feature: define SNAX_TCDM_ARB_PERF_EN to add per-port
// saturating stall counters on perf_stall_o.
module snax_tcdm_req_arbiter
  import snax_tcdm_arb_pkg::*;
#(
  parameter int unsigned NumInp         = NumInpDefault,
  parameter int unsigned DataWidth      = DataWidthDefault,
  parameter int unsigned MaxOutstanding = 8,
  parameter type         tcdm_req_t     = arb_req_t,
  parameter type         tcdm_rsp_t     = arb_rsp_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  tcdm_req_t in_req_i [NumInp],
  output tcdm_rsp_t in_rsp_o [NumInp],
  output tcdm_req_t out_req_o,
  input  tcdm_rsp_t out_rsp_i
`ifdef SNAX_TCDM_ARB_PERF_EN
  ,
  output logic [PerfCntWidth-1:0] perf_stall_o [NumInp]
`endif
);

  localparam int unsigned IdW = id_width(NumInp);

  logic [NumInp-1:0]    req_valid, q_ready;
  logic [IdW-1:0]       sel, head;
  logic                 arb_valid, sel_read, allow, handshake;
  logic                 fifo_full, fifo_empty, push, pop;
  logic [DataWidth-1:0] rsp_data;

  // Gather the per-port valids for the selector.
  always_comb begin
    for (int i = 0; i < NumInp; i++) req_valid[i] = in_req_i[i].q_valid;
  end

  snax_tcdm_rr_arbiter #(
    .NumInp (NumInp),
    .IdW    (IdW)
  ) i_rr_arbiter (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_valid),
    .out_valid_i (out_req_o.q_valid),
    .out_ready_i (out_rsp_i.q_ready),
    .sel_o       (sel),
    .valid_o     (arb_valid)
  );

  // Only reads need an ID slot, so only a read is held back by a full FIFO.
  assign sel_read  = ~in_req_i[sel].q.write;
  assign allow     = ~(sel_read & fifo_full);
  assign handshake = out_req_o.q_valid & out_rsp_i.q_ready;
  assign push      = handshake & sel_read;
  assign pop       = out_rsp_i.p_valid & ~fifo_empty;
  assign rsp_data  = out_rsp_i.p.data;

  // Forward the selected request toward TCDM.
  always_comb begin
    out_req_o         = in_req_i[sel];
    out_req_o.q_valid = arb_valid & allow;
  end

  // Ready goes only to the selected port.
  always_comb begin
    for (int i = 0; i < NumInp; i++)
      q_ready[i] = (sel == IdW'(i)) & out_rsp_i.q_ready & allow;
  end

  // Response data is broadcast; p_valid goes to the port that issued the oldest read.
  always_comb begin
    for (int i = 0; i < NumInp; i++) begin
      in_rsp_o[i]         = '0;
      in_rsp_o[i].p.data  = rsp_data;
      in_rsp_o[i].q_ready = q_ready[i];
      in_rsp_o[i].p_valid = (head == IdW'(i)) & pop;
    end
  end

  fifo_v3 #(
    .DATA_WIDTH (IdW),
    .DEPTH      (MaxOutstanding)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_i  (sel),
    .push_i  (push),
    .data_o  (head),
    .pop_i   (pop)
  );

  // A response with no outstanding read has nowhere to go and is dropped.
  rsp_without_read: assert property (@(posedge clk_i) disable iff (!rst_ni)
    out_rsp_i.p_valid |-> !fifo_empty);

`ifdef SNAX_TCDM_ARB_PERF_EN
  // Count cycles each port waits with a valid request, saturating at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumInp; i++) perf_stall_o[i] <= '0;
    end else begin
      for (int i = 0; i < NumInp; i++)
        if (req_valid[i] && !q_ready[i] && (perf_stall_o[i] != '1))
          perf_stall_o[i] <= perf_stall_o[i] + PerfCntWidth'(1);
    end
  end
`endif

endmodule
